// File: rtl/mash111_core.sv
// -----------------------------------------------------------------------------
// mash111_core
//
// Configurable MASH 1-1-1 delta-sigma modulator datapath. Up to three
// first-order accumulator stages are cascaded in a single cycle. Their carries
// are combined by the error-cancellation network into a signed modulus offset
// for a fractional-N divider. The accumulator width is set at run time by a
// thermometer mask (i_sum_sel) and a one-hot carry-bit select (i_cout_sel).
//
// Ports
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_frac           fractional word (ACC_W bits)
//   i_seed           seed word; only bits [ACC_W-1:0] are used
//   i_sel_order      00 = 1st order, 01 = 2nd order, 10/11 = 3rd order
//   i_sum_sel        accumulator mask, LSB-aligned thermometer code
//   i_cout_sel       one-hot select of the carry bit (ACC_W+1 bits)
//   i_mashreseten    level: clears the modulator and loads the seed into acc1
//   i_phaseadjusten  level: each rising edge adds the seed once to stage 1
//   i_sel_frac       forces the LSB of the effective fraction to 1 (dither)
//   o_dsm_out        registered signed modulator output (two's complement)
//   o_carry          registered stage carries {c3, c2, c1}
// -----------------------------------------------------------------------------
module mash111_core #(
    parameter int ACC_W = 8,
    parameter int OUT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [ACC_W-1:0] i_frac,
    input  logic [11:0]      i_seed,
    input  logic [1:0]       i_sel_order,
    input  logic [ACC_W-1:0] i_sum_sel,
    input  logic [ACC_W:0]   i_cout_sel,
    input  logic             i_mashreseten,
    input  logic             i_phaseadjusten,
    input  logic             i_sel_frac,
    output logic [OUT_W-1:0] o_dsm_out,
    output logic [2:0]       o_carry
);

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Zero-extend a single carry bit to a signed output-width value.
    function automatic logic signed [OUT_W-1:0] carry_to_signed(input logic c);
        return $signed({{(OUT_W-1){1'b0}}, c});
    endfunction

    // Error-cancellation network. Only the terms of the enabled stages take
    // part, so a stale delay value never leaks into a lower-order output.
    // The third-order span is -3..+4, which fits OUT_W = 4 without wrapping.
    function automatic logic signed [OUT_W-1:0] noise_cancel(
        input logic [1:0] order,
        input logic       c1,
        input logic       c2,
        input logic       c2_prev,
        input logic       c3,
        input logic       c3_prev,
        input logic       c3_prev2
    );
        logic signed [OUT_W-1:0] y;
        y = carry_to_signed(c1);
        if (order != 2'b00) begin
            y = y + carry_to_signed(c2) - carry_to_signed(c2_prev);
        end
        if (order[1]) begin
            y = y + carry_to_signed(c3)
                  - (carry_to_signed(c3_prev) <<< 1)
                  + carry_to_signed(c3_prev2);
        end
        return y;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ACC_W-1:0] acc1;
    logic [ACC_W-1:0] acc2;
    logic [ACC_W-1:0] acc3;
    logic             c2_d1;
    logic             c3_d1;
    logic             c3_d2;
    logic             phase_d;

    // -------------------------------------------------------------------------
    // Stage p0: combinational three-stage accumulate chain
    // -------------------------------------------------------------------------
    logic [ACC_W-1:0]        mask;
    logic [ACC_W-1:0]        seed_masked;
    logic [ACC_W-1:0]        frac_eff;
    logic                    phase_step;
    logic [ACC_W-1:0]        addend1_p0;
    logic [ACC_W:0]          sum1_p0;
    logic [ACC_W:0]          sum2_p0;
    logic [ACC_W:0]          sum3_p0;
    logic [ACC_W-1:0]        next1_p0;
    logic [ACC_W-1:0]        next2_p0;
    logic [ACC_W-1:0]        next3_p0;
    logic                    carry1_p0;
    logic                    carry2_p0;
    logic                    carry3_p0;
    logic                    en2;
    logic                    en3;
    logic signed [OUT_W-1:0] y_p0;

    assign mask        = i_sum_sel;
    assign seed_masked = i_seed[ACC_W-1:0] & mask;
    assign frac_eff    = (i_frac | {{(ACC_W-1){1'b0}}, i_sel_frac}) & mask;

    // Seed bits above the accumulator width carry no meaning here.
    generate
        if (ACC_W < 12) begin : g_seed_upper
            logic unused_seed_upper;
            assign unused_seed_upper = ^i_seed[11:ACC_W];
        end
    endgenerate

    // One phase step per low-to-high transition; suppressed while the
    // modulator is being cleared.
    assign phase_step = i_phaseadjusten & ~phase_d & ~i_mashreseten;
    assign addend1_p0 = phase_step ? seed_masked : frac_eff;

    assign en2 = (i_sel_order != 2'b00);
    assign en3 = i_sel_order[1];

    // Accumulator bits above the current mask are dropped before the add, so
    // a narrowed width takes effect immediately without a flush.
    assign sum1_p0   = {1'b0, acc1 & mask} + {1'b0, addend1_p0 & mask};
    assign carry1_p0 = |(sum1_p0 & i_cout_sel);
    assign next1_p0  = sum1_p0[ACC_W-1:0] & mask;

    assign sum2_p0   = {1'b0, acc2 & mask} + {1'b0, next1_p0};
    assign carry2_p0 = en2 & |(sum2_p0 & i_cout_sel);
    assign next2_p0  = en2 ? (sum2_p0[ACC_W-1:0] & mask) : '0;

    assign sum3_p0   = {1'b0, acc3 & mask} + {1'b0, next2_p0};
    assign carry3_p0 = en3 & |(sum3_p0 & i_cout_sel);
    assign next3_p0  = en3 ? (sum3_p0[ACC_W-1:0] & mask) : '0;

    assign y_p0 = noise_cancel(i_sel_order, carry1_p0, carry2_p0, c2_d1,
                               carry3_p0, c3_d1, c3_d2);

    // -------------------------------------------------------------------------
    // Stage p1: accumulator, delay-line and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc1      <= '0;
            acc2      <= '0;
            acc3      <= '0;
            c2_d1     <= 1'b0;
            c3_d1     <= 1'b0;
            c3_d2     <= 1'b0;
            phase_d   <= 1'b0;
            o_dsm_out <= '0;
            o_carry   <= '0;
        end else begin
            phase_d <= i_phaseadjusten;
            if (i_mashreseten) begin
                acc1      <= seed_masked;
                acc2      <= '0;
                acc3      <= '0;
                c2_d1     <= 1'b0;
                c3_d1     <= 1'b0;
                c3_d2     <= 1'b0;
                o_dsm_out <= '0;
                o_carry   <= '0;
            end else begin
                acc1      <= next1_p0;
                acc2      <= next2_p0;
                acc3      <= next3_p0;
                // Gated carries are already zero, which clears these delays.
                c2_d1     <= carry2_p0;
                c3_d1     <= carry3_p0;
                c3_d2     <= en3 ? c3_d1 : 1'b0;
                o_dsm_out <= y_p0;
                o_carry   <= {carry3_p0, carry2_p0, carry1_p0};
            end
        end
    end

endmodule

// File: tb/tb_mash111_core.sv
// -----------------------------------------------------------------------------
// tb_mash111_core
//
// Scoreboard bench for mash111_core. The stimulus process drives inputs on the
// falling edge and pushes the expected output of the following rising edge,
// taken from an integer MASH model, into a queue. A monitor pops and compares
// one entry after each rising edge and keeps running sum/min/max statistics
// that the stimulus process checks against closed-form expectations.
// -----------------------------------------------------------------------------
module tb_mash111_core;
    localparam int ACC_W = 8;
    localparam int OUT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [ACC_W-1:0] frac;
    logic [11:0]      seed;
    logic [1:0]       sel_order;
    logic [ACC_W-1:0] sum_sel;
    logic [ACC_W:0]   cout_sel;
    logic             mashrst;
    logic             pa;
    logic             sel_frac;
    logic [OUT_W-1:0] dsm_out;
    logic [2:0]       carry;

    int m;  // active accumulator width, 0..ACC_W

    always #5 clk = ~clk;

    assign sum_sel  = ACC_W'((1 << m) - 1);
    assign cout_sel = (ACC_W + 1)'(1 << m);

    mash111_core #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_frac          (frac),
        .i_seed          (seed),
        .i_sel_order     (sel_order),
        .i_sum_sel       (sum_sel),
        .i_cout_sel      (cout_sel),
        .i_mashreseten   (mashrst),
        .i_phaseadjusten (pa),
        .i_sel_frac      (sel_frac),
        .o_dsm_out       (dsm_out),
        .o_carry         (carry)
    );

    int checks = 0;
    int passes = 0;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act >= lo && act <= hi) passes++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // ---------------- reference model (integer arithmetic modulo 2^m) -------
    int a1, a2, a3, c2d, c3d1, c3d2, phd;
    logic [6:0] exp_q[$];

    task automatic model_step();
        int M, F, t, ad1, ord, c1, c2, c3, n1, n2, n3, y;
        logic [6:0] e;
        M   = (1 << m) - 1;
        ord = (sel_order > 2'd1) ? 3 : int'(sel_order) + 1;
        if (!rst_n) begin
            a1 = 0; a2 = 0; a3 = 0; c2d = 0; c3d1 = 0; c3d2 = 0; phd = 0;
            e = '0;
        end else if (mashrst) begin
            a1 = int'(seed) & M; a2 = 0; a3 = 0;
            c2d = 0; c3d1 = 0; c3d2 = 0; phd = int'(pa);
            e = '0;
        end else begin
            F   = (int'(frac) | int'(sel_frac)) & M;
            ad1 = (pa && phd == 0) ? (int'(seed) & M) : F;
            t = (a1 & M) + ad1; c1 = t >> m; n1 = t & M;
            c2 = 0; n2 = 0; c3 = 0; n3 = 0;
            if (ord >= 2) begin t = (a2 & M) + n1; c2 = t >> m; n2 = t & M; end
            if (ord >= 3) begin t = (a3 & M) + n2; c3 = t >> m; n3 = t & M; end
            case (ord)
                1:       y = c1;
                2:       y = c1 + c2 - c2d;
                default: y = c1 + c2 - c2d + c3 - 2 * c3d1 + c3d2;
            endcase
            e = {1'(c3), 1'(c2), 1'(c1), 4'(y)};
            c3d2 = (ord >= 3) ? c3d1 : 0;
            c3d1 = c3;
            c2d  = c2;
            a1 = n1; a2 = n2; a3 = n3;
            phd = int'(pa);
        end
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    task automatic mash_pulse();
        mashrst = 1'b1;
        drive_cycle();
        mashrst = 1'b0;
    endtask

    // ---------------- monitor --------------------------------------------
    int st_sum, st_min, st_max, st_n;

    task automatic clear_stats();
        st_sum = 0; st_min = 100; st_max = -100; st_n = 0;
    endtask

    initial begin
        logic [6:0] e;
        int v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val($sformatf("out_n%0d", st_n), int'({carry, dsm_out}), int'(e));
                v = int'($signed(dsm_out));
                st_sum += v;
                if (v < st_min) st_min = v;
                if (v > st_max) st_max = v;
                st_n++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // ---------------- stimulus --------------------------------------------
    initial begin
        bit seen;
        rst_n = 1'b0; frac = '0; seed = '0; sel_order = 2'b00; m = 4;
        mashrst = 1'b0; pa = 1'b0; sel_frac = 1'b0;
        a1 = 0; a2 = 0; a3 = 0; c2d = 0; c3d1 = 0; c3d2 = 0; phd = 0;
        clear_stats();
        @(negedge clk);
        run(3);
        check_val("reset_out", int'(dsm_out), 0);
        check_val("reset_carry", int'(carry), 0);
        rst_n = 1'b1;

        // Order 1, m=4, frac=4: one carry every fourth cycle.
        sel_order = 2'b00; m = 4; frac = 8'h04; seed = 12'h000;
        mash_pulse();
        clear_stats();
        run(64);
        check_val("o1_ones64", st_sum, 16);
        check_rng("o1_range", st_max, 0, 1);

        // Dither bit alone: effective fraction 1 at m=3.
        m = 3; frac = 8'h00; sel_frac = 1'b1;
        mash_pulse();
        clear_stats();
        run(32);
        check_val("dither_ones32", st_sum, 4);
        sel_frac = 1'b0;
        clear_stats();
        run(16);
        check_val("nodither_zero", st_sum, 0);

        // Order 2, m=8, frac=1/4.
        sel_order = 2'b01; m = 8; frac = 8'h40; seed = 12'h000;
        mash_pulse();
        clear_stats();
        run(1024);
        check_rng("o2_sum1024", st_sum, 254, 258);
        check_rng("o2_min", st_min, -1, 2);
        check_rng("o2_max", st_max, -1, 2);

        // Order 3, m=8, frac=1/256, seeded.
        sel_order = 2'b10; frac = 8'h01; seed = 12'h05A;
        mash_pulse();
        clear_stats();
        run(4096);
        check_rng("o3_sum4096", st_sum, 12, 20);
        check_rng("o3_min", st_min, -3, 4);
        check_rng("o3_max", st_max, -3, 4);

        // Phase adjust: two 3-cycle pulses of the enable, seed = half range.
        sel_order = 2'b00; m = 4; frac = 8'h00; seed = 12'h000;
        mash_pulse();
        seed = 12'h008;
        clear_stats();
        pa = 1'b1; run(3);
        pa = 1'b0; run(3);
        pa = 1'b1; run(3);
        pa = 1'b0; run(4);
        check_val("phase_ones", st_sum, 1);

        // Randomized configurations, including width changes without a flush.
        for (int blk = 0; blk < 8; blk++) begin
            sel_order = 2'($urandom_range(0, 3));
            m         = $urandom_range(0, ACC_W);
            frac      = 8'($urandom);
            seed      = 12'($urandom);
            sel_frac  = 1'($urandom_range(0, 1));
            for (int i = 0; i < 50; i++) begin
                mashrst = ($urandom_range(0, 39) == 0);
                pa      = ($urandom_range(0, 3) == 0);
                drive_cycle();
            end
        end
        mashrst = 1'b0; pa = 1'b0; sel_frac = 1'b0;

        // Hold the clear mid-stream, then async reset while the output is high.
        sel_order = 2'b10; m = 8; frac = 8'h37; seed = 12'h0C3;
        run(20);
        mashrst = 1'b1; run(3);
        mashrst = 1'b0; run(10);
        sel_order = 2'b00; m = 1; frac = 8'h01; seed = 12'h000;
        mash_pulse();
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            model_step();
            @(posedge clk);
            #3;
            if (dsm_out != '0) seen = 1'b1;
            else @(negedge clk);
        end
        check_val("pre_reset_nonzero", int'(seen), 1);
        rst_n = 1'b0;
        #1;
        check_val("async_reset_out", int'(dsm_out), 0);
        check_val("async_reset_carry", int'(carry), 0);
        @(negedge clk);
        run(2);
        rst_n = 1'b1;
        sel_order = 2'b10; m = 8; frac = 8'h5B;
        run(40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
